// File: rtl/sd_audio_pkg.sv
// Shared types and widths for the SD-card audio read path.
package sd_audio_pkg;

  localparam int unsigned AddrW          = 32;
  localparam int unsigned ByteW          = 8;
  localparam int unsigned FifoCntW       = 11;
  localparam int unsigned ByteCntW       = 10;
  localparam int unsigned BlockBytesDflt = 512;

  typedef enum logic [2:0] {
    StIdle,
    StWaitSpace,
    StIssue,
    StReceive,
    StWaitReady,
    StDone
  } sd_state_e;

endpackage

// File: rtl/sd_byte_capture.sv
// Turns the SD controller byte strobe into single-cycle FIFO writes and flags
// bytes that arrive while the FIFO is full.
module sd_byte_capture
  import sd_audio_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             byte_avail_i,
  input  logic [ByteW-1:0] data_i,
  input  logic             accept_i,
  input  logic             fifo_full_i,
  output logic             edge_o,
  output logic [ByteW-1:0] data_o,
  output logic             wr_en_o,
  output logic             overflow_o
);

  logic             avail_q;
  logic [ByteW-1:0] data_q, data_d;
  logic             wr_en_q, wr_en_d;
  logic             overflow_q, overflow_d;

  // The edge register tracks the strobe even outside a block so a level left
  // high across a state change never counts as a fresh byte.
  assign edge_o = accept_i & byte_avail_i & ~avail_q;

  always_comb begin
    data_d     = edge_o ? data_i : data_q;
    wr_en_d    = edge_o & ~fifo_full_i;
    overflow_d = overflow_q | (edge_o & fifo_full_i);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      avail_q    <= 1'b0;
      data_q     <= '0;
      wr_en_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      avail_q    <= byte_avail_i;
      data_q     <= data_d;
      wr_en_q    <= wr_en_d;
      overflow_q <= overflow_d;
    end
  end

  assign data_o     = data_q;
  assign wr_en_o    = wr_en_q;
  assign overflow_o = overflow_q;

endmodule

// File: rtl/sd_block_reader.sv
// Block-at-a-time SD read sequencer feeding the audio sample FIFO; requests a
// block only when the FIFO can absorb all of it.
module sd_block_reader
  import sd_audio_pkg::*;
#(
  parameter logic [AddrW-1:0] START_ADDR  = '0,
  parameter logic [AddrW-1:0] END_ADDR    = 32'h0100_0000,
  parameter int unsigned      BLOCK_BYTES = BlockBytesDflt,
  parameter int unsigned      FIFO_DEPTH  = 1024,
  parameter bit               LOOP        = 1'b1
) (
  input  logic                clk_in,
  input  logic                rst_n_in,
  input  logic                enable_in,
  input  logic                sd_ready_in,
  input  logic                sd_byte_available_in,
  input  logic [ByteW-1:0]    sd_dout_in,
  input  logic [FifoCntW-1:0] fifo_count_in,
  input  logic                fifo_full_in,
  output logic                sd_rd_out,
  output logic [AddrW-1:0]    sd_addr_out,
  output logic [ByteW-1:0]    fifo_din_out,
  output logic                fifo_wr_en_out,
  output logic                busy_out,
  output logic                done_out,
  output logic                overflow_err_out
);

  localparam logic [AddrW-1:0]    BlockStep  = AddrW'(BLOCK_BYTES);
  localparam logic [FifoCntW-1:0] SpaceLimit = FifoCntW'(FIFO_DEPTH - BLOCK_BYTES);
  localparam logic [ByteCntW-1:0] LastByte   = ByteCntW'(BLOCK_BYTES - 1);

  sd_state_e           state_q, state_d;
  logic [ByteCntW-1:0] byte_cnt_q, byte_cnt_d;
  logic [AddrW-1:0]    addr_q, addr_d;
  logic                rd_q, rd_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic             byte_edge;
  logic [AddrW-1:0] next_addr;
  logic             last_block;

  assign next_addr  = addr_q + BlockStep;
  assign last_block = (next_addr == END_ADDR);

  sd_byte_capture u_capture (
    .clk_i        (clk_in),
    .rst_ni       (rst_n_in),
    .byte_avail_i (sd_byte_available_in),
    .data_i       (sd_dout_in),
    .accept_i     (state_q == StReceive),
    .fifo_full_i  (fifo_full_in),
    .edge_o       (byte_edge),
    .data_o       (fifo_din_out),
    .wr_en_o      (fifo_wr_en_out),
    .overflow_o   (overflow_err_out)
  );

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q    <= StIdle;
      byte_cnt_q <= '0;
      addr_q     <= START_ADDR;
      rd_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      addr_q     <= addr_d;
      rd_q       <= rd_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    addr_d     = addr_q;
    unique case (state_q)
      StIdle: begin
        if (enable_in) state_d = StWaitSpace;
      end
      StWaitSpace: begin
        if (!enable_in) begin
          state_d = StIdle;
        end else if (sd_ready_in && (fifo_count_in <= SpaceLimit)) begin
          state_d = StIssue;
        end
      end
      StIssue: begin
        if (!sd_ready_in) state_d = StReceive;
      end
      StReceive: begin
        if (byte_edge) begin
          if (byte_cnt_q == LastByte) begin
            byte_cnt_d = '0;
            state_d    = StWaitReady;
          end else begin
            byte_cnt_d = byte_cnt_q + 1'b1;
          end
        end
      end
      StWaitReady: begin
        if (sd_ready_in) begin
          if (last_block && !LOOP) begin
            state_d = StDone;
          end else begin
            addr_d  = last_block ? START_ADDR : next_addr;
            // A pause request seen mid-block takes effect only here.
            state_d = enable_in ? StWaitSpace : StIdle;
          end
        end
      end
      StDone: begin
        if (!enable_in) begin
          state_d = StIdle;
          addr_d  = START_ADDR;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are decoded from the next state so they register alongside it.
  always_comb begin
    rd_d   = (state_d == StIssue);
    busy_d = (state_d == StIssue) || (state_d == StReceive) || (state_d == StWaitReady);
    done_d = (state_d == StDone);
  end

  assign sd_rd_out   = rd_q;
  assign sd_addr_out = addr_q;
  assign busy_out    = busy_q;
  assign done_out    = done_q;

endmodule

// File: tb/tb_sd_block_reader.sv
// Directed bench: an SD controller model streams blocks into two readers (loop
// and one-shot) while a monitor scores FIFO writes and read requests.
module tb_sd_block_reader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        sd_ready;
  logic        byte_av;
  logic [7:0]  dout;
  logic [10:0] fifo_count;
  logic        fifo_full;

  logic        a_rd, a_wr, a_busy, a_done, a_ovf;
  logic [31:0] a_addr;
  logic [7:0]  a_din;
  logic        b_rd, b_wr, b_busy, b_done, b_ovf;
  logic [31:0] b_addr;
  logic [7:0]  b_din;

  int n_cmp = 0;
  int n_err = 0;
  int wr_a  = 0;
  int wr_b  = 0;
  int rd_b  = 0;

  logic [7:0]  exp_q[$];
  logic [31:0] req_q[$];
  logic        a_rd_prev = 1'b0;
  logic        b_rd_prev = 1'b0;
  logic [7:0]  exp_byte;
  logic [31:0] exp_req;

  always #5 clk = ~clk;

  sd_block_reader #(
    .START_ADDR  (32'd0),
    .END_ADDR    (32'd1024),
    .BLOCK_BYTES (512),
    .FIFO_DEPTH  (1024),
    .LOOP        (1'b1)
  ) dut_a (
    .clk_in               (clk),
    .rst_n_in             (rst_n),
    .enable_in            (enable),
    .sd_ready_in          (sd_ready),
    .sd_byte_available_in (byte_av),
    .sd_dout_in           (dout),
    .fifo_count_in        (fifo_count),
    .fifo_full_in         (fifo_full),
    .sd_rd_out            (a_rd),
    .sd_addr_out          (a_addr),
    .fifo_din_out         (a_din),
    .fifo_wr_en_out       (a_wr),
    .busy_out             (a_busy),
    .done_out             (a_done),
    .overflow_err_out     (a_ovf)
  );

  sd_block_reader #(
    .START_ADDR  (32'd0),
    .END_ADDR    (32'd1024),
    .BLOCK_BYTES (512),
    .FIFO_DEPTH  (1024),
    .LOOP        (1'b0)
  ) dut_b (
    .clk_in               (clk),
    .rst_n_in             (rst_n),
    .enable_in            (enable),
    .sd_ready_in          (sd_ready),
    .sd_byte_available_in (byte_av),
    .sd_dout_in           (dout),
    .fifo_count_in        (fifo_count),
    .fifo_full_in         (fifo_full),
    .sd_rd_out            (b_rd),
    .sd_addr_out          (b_addr),
    .fifo_din_out         (b_din),
    .fifo_wr_en_out       (b_wr),
    .busy_out             (b_busy),
    .done_out             (b_done),
    .overflow_err_out     (b_ovf)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic flag_fail(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: unexpected event at %0t", name, $time);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_a_rd"},   32'(a_rd),   32'd0);
    check({tag, "_a_addr"}, a_addr,      32'd0);
    check({tag, "_a_din"},  32'(a_din),  32'd0);
    check({tag, "_a_wr"},   32'(a_wr),   32'd0);
    check({tag, "_a_busy"}, 32'(a_busy), 32'd0);
    check({tag, "_a_done"}, 32'(a_done), 32'd0);
    check({tag, "_a_ovf"},  32'(a_ovf),  32'd0);
    check({tag, "_b_done"}, 32'(b_done), 32'd0);
    check({tag, "_b_ovf"},  32'(b_ovf),  32'd0);
  endtask

  // Scoreboard monitor for dut_a; dut_b activity is only tallied.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (a_wr) begin
          wr_a++;
          if (exp_q.size() == 0) begin
            flag_fail("unexpected_write");
          end else begin
            exp_byte = exp_q.pop_front();
            check("wr_data", 32'(a_din), 32'(exp_byte));
          end
        end
        if (a_rd && !a_rd_prev) begin
          if (req_q.size() == 0) begin
            flag_fail("unexpected_request");
          end else begin
            exp_req = req_q.pop_front();
            check("req_addr", a_addr, exp_req);
            check("req_busy", 32'(a_busy), 32'd1);
          end
        end
        if (b_wr) wr_b++;
        if (b_rd && !b_rd_prev) rd_b++;
      end
      a_rd_prev = a_rd;
      b_rd_prev = b_rd;
    end
  end

  // SD controller model: accept the request, then stream 512 bytes.
  task automatic serve(input int blk, input logic [31:0] addr, input int hold,
                       input int full_lo, input int full_hi, input int drop_at,
                       input int rst_at);
    int n;
    n = 0;
    while (!a_rd && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!a_rd) begin
      flag_fail("request_timeout");
      return;
    end
    repeat (2) @(negedge clk);
    check("rd_hold", 32'(a_rd), 32'd1);
    check("addr_hold", a_addr, addr);
    sd_ready = 1'b0;
    @(negedge clk);
    check("rd_release", 32'(a_rd), 32'd0);
    check("busy_recv", 32'(a_busy), 32'd1);
    for (int i = 0; i < 512; i++) begin
      if (i == rst_at) begin
        rst_n = 1'b0;
        #1;
        check_reset("mid_rst");
        byte_av   = 1'b0;
        fifo_full = 1'b0;
        sd_ready  = 1'b1;
        return;
      end
      if (i == drop_at) enable = 1'b0;
      fifo_full = (i >= full_lo) && (i <= full_hi);
      dout      = 8'((i * 7 + blk * 31 + 3) % 256);
      if (!fifo_full) exp_q.push_back(dout);
      byte_av = 1'b1;
      repeat (hold) @(negedge clk);
      byte_av = 1'b0;
      @(negedge clk);
    end
    fifo_full = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n      = 1'b1;
    enable     = 1'b1;
    sd_ready   = 1'b1;
    byte_av    = 1'b0;
    dout       = 8'h00;
    fifo_count = 11'd0;
    fifo_full  = 1'b0;
    #1 rst_n = 1'b0;
    #1 check_reset("por");
    req_q.push_back(32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Block 0: single-cycle strobes at address 0.
    serve(0, 32'd0, 1, -1, -1, -1, -1);
    fifo_count = 11'd513;
    sd_ready   = 1'b1;
    repeat (3) @(negedge clk);
    check("blk0_writes_a", 32'(wr_a), 32'd512);
    check("blk0_writes_b", 32'(wr_b), 32'd512);
    check("blk0_next_addr", a_addr, 32'd512);
    check("blk0_idle_busy", 32'(a_busy), 32'd0);
    repeat (10) @(negedge clk);
    check("no_space_no_rd", 32'(a_rd), 32'd0);

    req_q.push_back(32'd512);
    fifo_count = 11'd512;
    @(negedge clk);
    check("space_rd_next_cycle", 32'(a_rd), 32'd1);

    // Block 1: stretched strobes, FIFO full for bytes 100..104.
    serve(1, 32'd512, 3, 100, 104, -1, -1);
    req_q.push_back(32'd0);
    fifo_count = 11'd0;
    sd_ready   = 1'b1;
    repeat (3) @(negedge clk);
    check("blk1_writes_a", 32'(wr_a), 32'd1019);
    check("blk1_writes_b", 32'(wr_b), 32'd1019);
    check("ovf_a_set", 32'(a_ovf), 32'd1);
    check("ovf_b_set", 32'(b_ovf), 32'd1);
    check("b_done", 32'(b_done), 32'd1);
    check("b_done_addr", b_addr, 32'd512);
    check("a_not_done", 32'(a_done), 32'd0);

    // Block 2: loop back to 0, pause at byte 200.
    serve(2, 32'd0, 1, -1, -1, 200, -1);
    sd_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("blk2_writes_a", 32'(wr_a), 32'd1531);
    check("b_ignored_bytes", 32'(wr_b), 32'd1019);
    check("b_no_rd_in_done", 32'(rd_b), 32'd2);
    check("pause_addr", a_addr, 32'd512);
    check("pause_busy", 32'(a_busy), 32'd0);
    check("pause_rd", 32'(a_rd), 32'd0);
    check("b_idle_addr", b_addr, 32'd0);
    check("b_idle_done", 32'(b_done), 32'd0);
    check("ovf_sticky", 32'(a_ovf), 32'd1);

    // Block 3: resume at 512, reset arrives at byte 300.
    req_q.push_back(32'd512);
    enable = 1'b1;
    repeat (2) @(negedge clk);
    check("b_restart_rd", 32'(b_rd), 32'd1);
    check("b_restart_addr", b_addr, 32'd0);
    serve(3, 32'd512, 1, -1, -1, -1, 300);
    check("rst_drained", 32'(exp_q.size()), 32'd0);
    check("blk3_writes_a", 32'(wr_a), 32'd1831);
    enable = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_rd", 32'(a_rd), 32'd0);
    check("post_rst_addr", a_addr, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
